// File: rtl/particle_evt_pkg.sv
// Shared types for the particle event extractor: event record, FSM states,
// record width and saturation limits.
package particle_evt_pkg;

    localparam int PEV_IDX_W = 32;
    localparam int PEV_SUM_W = 32;

    localparam logic [15:0] LEN_SAT  = 16'hFFFF;
    localparam logic [15:0] DROP_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        EVT_IDLE = 2'd0,
        EVT_RUN  = 2'd1,
        EVT_GAP  = 2'd2
    } evt_state_e;

    typedef struct packed {
        logic [PEV_IDX_W-1:0] start;
        logic [15:0]          len;
        logic [15:0]          peak;
        logic [15:0]          peak_data;
        logic [PEV_SUM_W-1:0] sum;
        logic                 acc;
    } evt_rec_t;

    localparam int REC_W = $bits(evt_rec_t);

    // A programmed minimum length of zero behaves like one.
    function automatic logic [15:0] min_len_eff(input logic [15:0] m);
        return (m == 16'd0) ? 16'd1 : m;
    endfunction

endpackage

// File: rtl/particle_event_extract_if.sv
// Filter-stage sample stream and event-record handshake of the extractor.
interface particle_event_extract_if #(
    parameter int IDX_W = 32,
    parameter int SUM_W = 32
);
    logic             filter_vld_i;
    logic [15:0]      filter_data_i;
    logic [15:0]      filter_haze_hub_i;
    logic             filter_curr_result_i;
    logic             filter_acc_flag_i;
    logic             evt_rdy_i;
    logic             evt_vld_o;
    logic [IDX_W-1:0] evt_start_o;
    logic [15:0]      evt_len_o;
    logic [15:0]      evt_peak_o;
    logic [15:0]      evt_peak_data_o;
    logic [SUM_W-1:0] evt_sum_o;
    logic             evt_acc_o;

    modport master (
        output filter_vld_i, filter_data_i, filter_haze_hub_i,
               filter_curr_result_i, filter_acc_flag_i, evt_rdy_i,
        input  evt_vld_o, evt_start_o, evt_len_o, evt_peak_o,
               evt_peak_data_o, evt_sum_o, evt_acc_o
    );

    modport slave (
        input  filter_vld_i, filter_data_i, filter_haze_hub_i,
               filter_curr_result_i, filter_acc_flag_i, evt_rdy_i,
        output evt_vld_o, evt_start_o, evt_len_o, evt_peak_o,
               evt_peak_data_o, evt_sum_o, evt_acc_o
    );
endinterface

// File: rtl/particle_evt_fifo.sv
// First-word-fall-through record FIFO: storage array plus a registered head
// stage; total capacity (array + head) is DEPTH records.
module particle_evt_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      mem_cnt_q, mem_cnt_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [AW+1:0]    total_s;
    logic             pop_s, full_s, wr_ok_s, load_s;

    // Head refill, write acceptance and occupancy bookkeeping.
    always_comb begin
        pop_s     = rd_en_i & out_vld_q;
        total_s   = {1'b0, mem_cnt_q} + {{(AW+1){1'b0}}, out_vld_q};
        full_s    = (total_s == (AW+2)'(DEPTH));
        wr_ok_s   = wr_en_i & (~full_s | pop_s);
        load_s    = (~out_vld_q | pop_s) & (mem_cnt_q != '0);
        mem_cnt_d = mem_cnt_q + (AW+1)'(wr_ok_s) - (AW+1)'(load_s);
        wr_ptr_d  = wr_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = load_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        if (load_s) begin
            out_vld_d = 1'b1;
            out_d     = mem_q[rd_ptr_q];
        end else if (pop_s) begin
            out_vld_d = 1'b0;
            out_d     = out_q;
        end else begin
            out_vld_d = out_vld_q;
            out_d     = out_q;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
        end
    end

    assign rd_data_o = out_q;
    assign empty_o   = ~out_vld_q;
    assign full_o    = full_s;
endmodule

// File: rtl/particle_event_extract.sv
// Groups threshold hits into particle events and queues one record per event.
// Optional feature: define PARTICLE_MAXLEN_EN to force-split runs at MAX_LEN.
module particle_event_extract
    import particle_evt_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int IDX_W      = 32,
    parameter int SUM_W      = 32,
    parameter int MAX_LEN    = 4096
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    particle_event_extract_if.slave bus,
    input  logic [15:0]             min_len_i,
    input  logic [7:0]              merge_gap_i,
    output logic [15:0]             drop_cnt_o,
    output logic                    overflow_o
);
`ifdef PARTICLE_MAXLEN_EN
    localparam bit MAXLEN_EN = 1'b1;
`else
    localparam bit MAXLEN_EN = 1'b0;
`endif

    evt_state_e       state_q, state_d, st_s;
    logic [IDX_W-1:0] idx_q, idx_d, start_q, start_d, diff_s;
    logic [15:0]      len_q, len_d, peak_q, peak_d, peak_data_q, peak_data_d;
    logic [SUM_W-1:0] sum_q, sum_d, sum_sat_s;
    logic [SUM_W:0]   sum_add_s;
    logic [15:0]      hit_len_s, drop_cnt_q, drop_cnt_d;
    logic [8:0]       gap_q, gap_d;
    logic             acc_q, acc_d, acc_prev_q, acc_prev_d;
    logic             close_s, close_old_s, push_q, push_d;
    logic             overflow_q, overflow_d, fifo_full_s, fifo_empty_s, pop_s, drop_s;
    evt_rec_t         rec_s, rec_q, rec_d, head_s;
    logic [REC_W-1:0] fifo_rd_s;

    // Event FSM; an acc change first closes the open run with its old state.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_prev_d  = acc_prev_q;
        start_d     = start_q;
        len_d       = len_q;
        peak_d      = peak_q;
        peak_data_d = peak_data_q;
        sum_d       = sum_q;
        acc_d       = acc_q;
        gap_d       = gap_q;
        st_s        = state_q;
        close_s     = 1'b0;
        close_old_s = 1'b0;
        diff_s      = idx_q - start_q;
        if (len_q == LEN_SAT || diff_s >= IDX_W'(32'd65534)) begin
            hit_len_s = LEN_SAT;
        end else begin
            hit_len_s = diff_s[15:0] + 16'd1;
        end
        sum_add_s = {1'b0, sum_q} + (SUM_W+1)'(bus.filter_haze_hub_i);
        if (sum_add_s[SUM_W]) begin
            sum_sat_s = '1;
        end else begin
            sum_sat_s = sum_add_s[SUM_W-1:0];
        end
        if (bus.filter_vld_i) begin
            idx_d      = idx_q + IDX_W'(1);
            acc_prev_d = bus.filter_acc_flag_i;
            if (state_q != EVT_IDLE && bus.filter_acc_flag_i != acc_prev_q) begin
                close_s     = 1'b1;
                close_old_s = 1'b1;
                st_s        = EVT_IDLE;
            end else begin
                st_s = state_q;
            end
            case (st_s)
                EVT_IDLE: begin
                    if (bus.filter_curr_result_i) begin
                        state_d     = EVT_RUN;
                        start_d     = idx_q;
                        len_d       = 16'd1;
                        peak_d      = bus.filter_haze_hub_i;
                        peak_data_d = bus.filter_data_i;
                        sum_d       = SUM_W'(bus.filter_haze_hub_i);
                        acc_d       = bus.filter_acc_flag_i;
                    end else begin
                        state_d = EVT_IDLE;
                    end
                end
                EVT_RUN, EVT_GAP: begin
                    if (bus.filter_curr_result_i) begin
                        state_d = EVT_RUN;
                        len_d   = hit_len_s;
                        sum_d   = sum_sat_s;
                        if (bus.filter_haze_hub_i > peak_q) begin
                            peak_d      = bus.filter_haze_hub_i;
                            peak_data_d = bus.filter_data_i;
                        end else begin
                            peak_d = peak_q;
                        end
                        if (MAXLEN_EN && 32'(hit_len_s) >= 32'(MAX_LEN)) begin
                            close_s = 1'b1;
                            state_d = EVT_IDLE;
                        end else begin
                            close_s = 1'b0;
                        end
                    end else if (st_s == EVT_RUN && merge_gap_i == 8'd0) begin
                        close_s = 1'b1;
                        state_d = EVT_IDLE;
                    end else if (st_s == EVT_RUN) begin
                        state_d = EVT_GAP;
                        gap_d   = 9'd1;
                    end else if (gap_q == {1'b0, merge_gap_i}) begin
                        close_s = 1'b1;
                        state_d = EVT_IDLE;
                    end else begin
                        gap_d = gap_q + 9'd1;
                    end
                end
                default: state_d = EVT_IDLE;
            endcase
        end else begin
            st_s = state_q;
        end
        rec_s.start     = PEV_IDX_W'(close_old_s ? start_q : start_d);
        rec_s.len       = close_old_s ? len_q : len_d;
        rec_s.peak      = close_old_s ? peak_q : peak_d;
        rec_s.peak_data = close_old_s ? peak_data_q : peak_data_d;
        rec_s.sum       = PEV_SUM_W'(close_old_s ? sum_q : sum_d);
        rec_s.acc       = close_old_s ? acc_q : acc_d;
        push_d          = close_s & (rec_s.len >= min_len_eff(min_len_i));
        rec_d           = rec_s;
    end

    // Drop accounting: a push into a full FIFO with no same-cycle pop is lost.
    always_comb begin
        pop_s      = bus.evt_rdy_i & ~fifo_empty_s;
        drop_s     = push_q & fifo_full_s & ~pop_s;
        overflow_d = overflow_q | drop_s;
        if (drop_s && drop_cnt_q != DROP_SAT) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // State, accumulator and record-staging registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= EVT_IDLE;
            idx_q       <= '0;
            acc_prev_q  <= 1'b0;
            start_q     <= '0;
            len_q       <= 16'd0;
            peak_q      <= 16'd0;
            peak_data_q <= 16'd0;
            sum_q       <= '0;
            acc_q       <= 1'b0;
            gap_q       <= 9'd0;
            push_q      <= 1'b0;
            rec_q       <= '0;
            drop_cnt_q  <= 16'd0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_prev_q  <= acc_prev_d;
            start_q     <= start_d;
            len_q       <= len_d;
            peak_q      <= peak_d;
            peak_data_q <= peak_data_d;
            sum_q       <= sum_d;
            acc_q       <= acc_d;
            gap_q       <= gap_d;
            push_q      <= push_d;
            rec_q       <= rec_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    particle_evt_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REC_W)) u_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (push_q),
        .wr_data_i (rec_q),
        .rd_en_i   (bus.evt_rdy_i),
        .rd_data_o (fifo_rd_s),
        .empty_o   (fifo_empty_s),
        .full_o    (fifo_full_s)
    );

    assign head_s              = evt_rec_t'(fifo_rd_s);
    assign bus.evt_vld_o       = ~fifo_empty_s;
    assign bus.evt_start_o     = IDX_W'(head_s.start);
    assign bus.evt_len_o       = head_s.len;
    assign bus.evt_peak_o      = head_s.peak;
    assign bus.evt_peak_data_o = head_s.peak_data;
    assign bus.evt_sum_o       = SUM_W'(head_s.sum);
    assign bus.evt_acc_o       = head_s.acc;
    assign drop_cnt_o          = drop_cnt_q;
    assign overflow_o          = overflow_q;
endmodule

// File: tb/tb_particle_event_extract.sv
// Directed scenario bench for particle_event_extract (default build).
module tb_particle_event_extract;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] min_len = 16'd1;
    logic [7:0]  merge_gap = 8'd0;
    logic [15:0] drop_cnt;
    logic        overflow;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] c_start [32];
    logic [15:0] c_len [32];
    logic [15:0] c_peak [32];
    logic [15:0] c_pdata [32];
    logic [31:0] c_sum [32];
    logic        c_acc [32];
    int          n_rec;

    particle_event_extract_if #(.IDX_W(32), .SUM_W(32)) bus ();

    particle_event_extract #(.FIFO_DEPTH(16), .IDX_W(32), .SUM_W(32), .MAX_LEN(4096)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bus         (bus),
        .min_len_i   (min_len),
        .merge_gap_i (merge_gap),
        .drop_cnt_o  (drop_cnt),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        bus.filter_vld_i = 1'b0; bus.filter_data_i = 16'd0; bus.filter_haze_hub_i = 16'd0;
        bus.filter_curr_result_i = 1'b0; bus.filter_acc_flag_i = 1'b0; bus.evt_rdy_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic hit, input logic [15:0] hub, input logic [15:0] data, input logic acc);
        @(negedge clk);
        bus.filter_vld_i = 1'b1; bus.filter_curr_result_i = hit;
        bus.filter_haze_hub_i = hub; bus.filter_data_i = data; bus.filter_acc_flag_i = acc;
    endtask

    task automatic collect(input int max_cycles);
        @(negedge clk);
        bus.filter_vld_i = 1'b0; bus.filter_curr_result_i = 1'b0;
        bus.evt_rdy_i = 1'b1;
        n_rec = 0;
        for (int c = 0; c < max_cycles; c++) begin
            if (bus.evt_vld_o && n_rec < 32) begin
                c_start[n_rec] = bus.evt_start_o; c_len[n_rec] = bus.evt_len_o;
                c_peak[n_rec] = bus.evt_peak_o; c_pdata[n_rec] = bus.evt_peak_data_o;
                c_sum[n_rec] = bus.evt_sum_o; c_acc[n_rec] = bus.evt_acc_o;
                n_rec++;
            end
            @(negedge clk);
        end
        bus.evt_rdy_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (bus.evt_vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b want 0", bus.evt_vld_o); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
        checks++; if (bus.evt_start_o !== 32'd0 || bus.evt_sum_o !== 32'd0) begin errors++;
            $display("FAIL reset_fields: start %0h sum %0h want 0", bus.evt_start_o, bus.evt_sum_o); end
    endtask

    task automatic test_basic();
        logic [15:0] hubs [5];
        hubs = '{16'd5, 16'd9, 16'd9, 16'd2, 16'd1};
        do_reset();
        min_len = 16'd3; merge_gap = 8'd0;
        for (int i = 0; i < 10; i++) send(1'b0, 16'd0, 16'h1000 + 16'(i), 1'b0);
        for (int i = 0; i < 5; i++) send(1'b1, hubs[i], 16'h100A + 16'(i), 1'b0);
        send(1'b0, 16'd0, 16'h100F, 1'b0);
        collect(30);
        checks++; if (n_rec !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", n_rec); end
        checks++; if (c_start[0] !== 32'd10 || c_len[0] !== 16'd5) begin errors++;
            $display("FAIL basic_start_len: got %0d/%0d want 10/5", c_start[0], c_len[0]); end
        checks++; if (c_peak[0] !== 16'd9 || c_pdata[0] !== 16'h100B) begin errors++;
            $display("FAIL basic_peak: got %0d/%0h want 9/100b", c_peak[0], c_pdata[0]); end
        checks++; if (c_sum[0] !== 32'd26 || c_acc[0] !== 1'b0) begin errors++;
            $display("FAIL basic_sum_acc: got %0d/%0b want 26/0", c_sum[0], c_acc[0]); end
    endtask

    task automatic test_merge_gap();
        do_reset();
        min_len = 16'd1; merge_gap = 8'd2;
        for (int i = 0; i < 11; i++)
            send((i < 4 || i == 6 || i == 7) ? 1'b1 : 1'b0, 16'd1, 16'(i), 1'b0);
        collect(30);
        checks++; if (n_rec !== 1 || c_start[0] !== 32'd0 || c_len[0] !== 16'd8 || c_sum[0] !== 32'd6) begin errors++;
            $display("FAIL merge_bridge: got n=%0d start=%0d len=%0d sum=%0d want 1/0/8/6", n_rec, c_start[0], c_len[0], c_sum[0]); end
        do_reset();
        for (int i = 0; i < 12; i++)
            send((i < 4 || i == 7 || i == 8) ? 1'b1 : 1'b0, 16'd1, 16'(i), 1'b0);
        collect(30);
        checks++; if (n_rec !== 2) begin errors++; $display("FAIL merge_split_count: got %0d want 2", n_rec); end
        checks++; if (c_start[0] !== 32'd0 || c_len[0] !== 16'd4 || c_start[1] !== 32'd7 || c_len[1] !== 16'd2) begin errors++;
            $display("FAIL merge_split_recs: got %0d/%0d %0d/%0d want 0/4 7/2", c_start[0], c_len[0], c_start[1], c_len[1]); end
    endtask

    task automatic test_min_len();
        do_reset();
        min_len = 16'd4; merge_gap = 8'd0;
        for (int i = 0; i < 10; i++)
            send((i >= 1 && i <= 3) || (i >= 5 && i <= 8) ? 1'b1 : 1'b0, 16'd3, 16'(i), 1'b0);
        collect(30);
        checks++; if (n_rec !== 1 || c_start[0] !== 32'd5 || c_len[0] !== 16'd4) begin errors++;
            $display("FAIL minlen_filter: got n=%0d start=%0d len=%0d want 1/5/4", n_rec, c_start[0], c_len[0]); end
        checks++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin errors++;
            $display("FAIL minlen_nodrop: got %0d/%0b want 0/0", drop_cnt, overflow); end
    endtask

    task automatic test_acc_split();
        do_reset();
        min_len = 16'd1; merge_gap = 8'd0;
        for (int i = 0; i < 20; i++) send(1'b0, 16'd0, 16'(i), 1'b0);
        for (int i = 20; i < 25; i++) send(1'b1, 16'd2, 16'(i), 1'b0);
        for (int i = 25; i < 30; i++) send(1'b1, 16'd3, 16'(i), 1'b1);
        send(1'b0, 16'd0, 16'd30, 1'b1);
        collect(30);
        checks++; if (n_rec !== 2) begin errors++; $display("FAIL acc_count: got %0d want 2", n_rec); end
        checks++; if (c_start[0] !== 32'd20 || c_len[0] !== 16'd5 || c_acc[0] !== 1'b0 || c_sum[0] !== 32'd10) begin errors++;
            $display("FAIL acc_first: got %0d/%0d/%0b/%0d want 20/5/0/10", c_start[0], c_len[0], c_acc[0], c_sum[0]); end
        checks++; if (c_start[1] !== 32'd25 || c_len[1] !== 16'd5 || c_acc[1] !== 1'b1 || c_sum[1] !== 32'd15) begin errors++;
            $display("FAIL acc_second: got %0d/%0d/%0b/%0d want 25/5/1/15", c_start[1], c_len[1], c_acc[1], c_sum[1]); end
    endtask

    task automatic test_fifo_full();
        logic [31:0] snap_start, snap_sum;
        do_reset();
        min_len = 16'd1; merge_gap = 8'd0;
        for (int k = 0; k < 17; k++) begin
            send(1'b1, 16'(k + 1), 16'h2000 + 16'(k), 1'b0);
            send(1'b0, 16'd0, 16'd0, 1'b0);
        end
        @(negedge clk);
        bus.filter_vld_i = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (drop_cnt !== 16'd1 || overflow !== 1'b1) begin errors++;
            $display("FAIL full_drop: got %0d/%0b want 1/1", drop_cnt, overflow); end
        checks++; if (bus.evt_vld_o !== 1'b1 || bus.evt_start_o !== 32'd0) begin errors++;
            $display("FAIL full_head: got vld=%0b start=%0d want 1/0", bus.evt_vld_o, bus.evt_start_o); end
        snap_start = bus.evt_start_o; snap_sum = bus.evt_sum_o;
        repeat (3) @(negedge clk);
        checks++; if (bus.evt_start_o !== snap_start || bus.evt_sum_o !== snap_sum || snap_sum !== 32'd1) begin errors++;
            $display("FAIL full_stable: got %0d/%0d want %0d/1", bus.evt_start_o, bus.evt_sum_o, snap_start); end
        collect(40);
        checks++; if (n_rec !== 16) begin errors++; $display("FAIL full_drain_count: got %0d want 16", n_rec); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (c_start[k] !== 32'(2 * k) || c_pdata[k] !== 16'h2000 + 16'(k) || c_peak[k] !== 16'(k + 1)) begin errors++;
                $display("FAIL full_order[%0d]: got %0d/%0h/%0d want %0d/%0h/%0d", k, c_start[k], c_pdata[k], c_peak[k],
                         2 * k, 16'h2000 + 16'(k), k + 1); end
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        min_len = 16'd1; merge_gap = 8'd0;
        send(1'b1, 16'd4, 16'd0, 1'b0);
        send(1'b0, 16'd0, 16'd1, 1'b0);
        send(1'b1, 16'd4, 16'd2, 1'b0);
        send(1'b1, 16'd4, 16'd3, 1'b0);
        @(negedge clk);
        bus.filter_vld_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.evt_vld_o !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %0b want 1", bus.evt_vld_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.evt_vld_o !== 1'b0) begin errors++; $display("FAIL midrst_vld: got %0b want 0", bus.evt_vld_o); end
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b1, 16'd7, 16'h0077, 1'b0);
        send(1'b0, 16'd0, 16'd0, 1'b0);
        collect(20);
        checks++; if (n_rec !== 1 || c_start[0] !== 32'd0 || c_peak[0] !== 16'd7 || c_len[0] !== 16'd1) begin errors++;
            $display("FAIL midrst_restart: got n=%0d start=%0d peak=%0d len=%0d want 1/0/7/1", n_rec, c_start[0], c_peak[0], c_len[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_merge_gap();
        test_min_len();
        test_acc_split();
        test_fifo_full();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/particle_event_extract.md
Name: particle_event_extract

Overview:
- Sits directly downstream of the particle threshold filter stage.
- Consumes its per-sample stream: valid, raw data, haze-subtracted magnitude ("haze hub"), threshold hit, acc flag.
- Groups consecutive hit samples (tolerating short gaps) into particle events and measures start index, length, peak and sum.
- Pushes one record per qualifying event into an output FIFO with a valid/ready handshake toward the packer/uplink stage.

Parameters:
FIFO_DEPTH, 16, event FIFO depth (power of 2, >=4)
IDX_W, 32, sample index width
SUM_W, 32, haze-hub accumulator width
MAX_LEN, 4096, forced-split length (used only with PARTICLE_MAXLEN_EN)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
filter_vld_i  in  1  sample valid from filter stage
filter_data_i  in  16  raw laser data
filter_haze_hub_i  in  16  haze-subtracted magnitude, clamped >=0
filter_curr_result_i  in  1  1 = sample above threshold
filter_acc_flag_i  in  1  acceleration-segment flag
min_len_i  in  16  minimum event length to report (0 treated as 1)
merge_gap_i  in  8  max consecutive non-hit samples bridged inside one event
evt_rdy_i  in  1  consumer ready
evt_vld_o  out  1  event record valid
evt_start_o  out  IDX_W  sample index of first hit
evt_len_o  out  16  last_hit_idx - start_idx + 1, saturating at 0xFFFF
evt_peak_o  out  16  max haze hub over hit samples
evt_peak_data_o  out  16  filter_data at first occurrence of peak
evt_sum_o  out  SUM_W  sum of haze hub over hit samples, saturating
evt_acc_o  out  1  acc flag of event
drop_cnt_o  out  16  events lost to FIFO full, saturating
overflow_o  out  1  sticky, set on first drop

Behaviour:
- Reset (rst_n_i low, async): FSM=IDLE, index=0, accumulators=0, FIFO empty, all outputs 0.
- Only cycles with filter_vld_i=1 advance logic; idle cycles hold all state.
- sample_idx increments on every valid sample and wraps at 2^IDX_W; events carry the index of their first hit.
- acc_prev register holds the acc flag of the last valid sample.
- FSM:
  - IDLE: hit -> RUN. Load start=idx, peak, peak_data, sum=hub, len=1, acc=acc_i.
  - RUN: hit -> update. Non-hit with merge_gap_i=0 -> close. Otherwise non-hit -> GAP, gap_cnt=1.
  - GAP: hit -> RUN; len = idx-start+1, gap samples not in peak/sum. Non-hit: gap_cnt++. gap_cnt reaching merge_gap_i+1 -> close.
- Close: if len>=max(min_len_i,1), push record. Otherwise discard silently (no drop count). FSM -> IDLE.
- Acc boundary: a valid sample with acc_i != acc_prev first closes any open run (record keeps the old acc). The same sample is then evaluated from IDLE, so a hit starts a new event on that cycle.
- Peak ties keep the earliest sample.
- Sum saturates at 2^SUM_W-1; length saturates at 0xFFFF.
- Latency: the closing sample is sampled at edge N; the record is written to FIFO at edge N+1; evt_vld_o rises after edge N+2 if the FIFO was empty.
- FIFO: first-word-fall-through. Record pops on evt_vld_o & evt_rdy_i.
- Full: a push while full drops the new record; drop_cnt_o++ (saturating) and overflow_o=1. An opposite pop on the same cycle frees space and the push succeeds.
- Outputs hold stable while evt_vld_o=1 & evt_rdy_i=0.
- min_len_i/merge_gap_i are sampled live; change them only while idle.

Optional Feature:
- PARTICLE_MAXLEN_EN defined: when len reaches MAX_LEN in RUN, the event closes on that sample. The next hit opens a new event with start = next index.
- Not defined: runs grow unbounded, length saturating at 0xFFFF.

Decomposition:
- Package particle_evt_pkg holds:
  - event record struct (start, len, peak, peak_data, sum, acc);
  - FSM state enum IDLE/RUN/GAP;
  - record width constant;
  - saturation max constants.
- One sub-module: particle_evt_fifo, a synchronous FWFT FIFO of packed records with full/empty flags.

Test Plan:
- min_len_i=3, merge_gap_i=0; hits at idx 10..14, hub=5,9,9,2,1 -> one record: start=10, len=5, peak=9 (data of idx 11), sum=26.
- merge_gap_i=2; hits 0..3, miss 4..5, hits 6..7 -> one event, start=0, len=8. With 3 misses (4..6) -> two events.
- min_len_i=4; 3-sample hit run -> no record, drop_cnt_o=0.
- Hit run 20..29 with acc flipping at idx 25 -> two records: (20, len 5, acc old) and (25, len 5, acc new).
- evt_rdy_i=0, generate 17 events with FIFO_DEPTH=16 -> drop_cnt_o=1, overflow_o=1. Releasing ready drains 16 records in order; outputs stay stable while stalled.
- Assert rst_n_i mid-RUN -> evt_vld_o=0 immediately; first hit after release reports start=0.
